// File: rtl/action_lookup_arbiter.sv
// action_lookup_arbiter: round-robin arbiter that issues per-requester ruleID lookups to a
// fixed-latency action table and routes each returned action bit back to its requester.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ruleID    per-requester lookup request and key (slice i = [i*w_ruleID +: w_ruleID])
//   req_ready               per-requester accept (registered, ~pend)
//   rsp_valid/rsp_action    one-cycle response pulse and action bit to the owning requester
//   hold                    blocks new issue to the table while 1
//   ruleID_valid/ruleID     registered lookup strobe and key to the action table
//   action_valid/action     table result, LAT cycles after ruleID_valid
//   err_orphan/err_missing  sticky: result without tag / tag without result
//   lookup_cnt              wrapping count of issued lookups
module action_lookup_arbiter #(
   parameter int N_REQ    = 4,
   parameter int w_ruleID = 16,
   parameter int LAT      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*w_ruleID-1:0] req_ruleID,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [N_REQ-1:0]          rsp_action,
   input  logic                      hold,
   output logic                      ruleID_valid,
   output logic [w_ruleID-1:0]       ruleID,
   input  logic                      action_valid,
   input  logic                      action,
   output logic                      err_orphan,
   output logic                      err_missing,
   output logic [31:0]               lookup_cnt
);
   localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int DW = $clog2(LAT + 1);
   logic [N_REQ-1:0]    pend;
   logic [w_ruleID-1:0] key [N_REQ];
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       gnt_idx;
   logic                gnt;
   // tag_v[0] is loaded alongside ruleID_valid; tag_v[LAT] lines up with that lookup's action_valid
   logic [LAT:0]        tag_v;
   logic [IW-1:0]       tag_i [LAT+1];
   logic [DW-1:0]       drain;
   int                  j;

   assign req_ready = ~pend;

   always_comb begin
      gnt     = 1'b0;
      gnt_idx = last_grant;
      j       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(last_grant) + k) % N_REQ;
         if (!gnt && pend[j] && !hold) begin
            gnt     = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++)
         if (req_valid[i] && !pend[i]) key[i] <= req_ruleID[i*w_ruleID +: w_ruleID];
      tag_i[0] <= gnt_idx;
      for (int k = 1; k <= LAT; k++) tag_i[k] <= tag_i[k-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend         <= '0;
         last_grant   <= IW'(N_REQ - 1);
         ruleID_valid <= 1'b0;
         ruleID       <= '0;
         lookup_cnt   <= '0;
         tag_v        <= '0;
         rsp_valid    <= '0;
         rsp_action   <= '0;
         err_orphan   <= 1'b0;
         err_missing  <= 1'b0;
         drain        <= DW'(LAT);
      end else begin
         // a granted requester is never accepted in the same cycle since its pend is still set
         for (int i = 0; i < N_REQ; i++)
            if (req_valid[i] && !pend[i]) pend[i] <= 1'b1;
         if (gnt) begin
            pend[gnt_idx] <= 1'b0;
            last_grant    <= gnt_idx;
            ruleID        <= key[gnt_idx];
            lookup_cnt    <= lookup_cnt + 32'd1;
         end
         ruleID_valid <= gnt;
         tag_v        <= {tag_v[LAT-1:0], gnt};
         rsp_valid    <= '0;
         rsp_action   <= '0;
         if (action_valid && tag_v[LAT]) begin
            rsp_valid[tag_i[LAT]]  <= 1'b1;
            rsp_action[tag_i[LAT]] <= action;
         end
         // stale table results from before reset are ignored until the drain counter empties
         if (action_valid && !tag_v[LAT] && ~|drain) err_orphan <= 1'b1;
         if (!action_valid && tag_v[LAT]) err_missing <= 1'b1;
         if (|drain) drain <= drain - 1'b1;
      end
   end
endmodule

// File: tb/tb_action_lookup_arbiter.sv
// tb_action_lookup_arbiter: scoreboard bench with a behavioural fixed-latency action table.
module tb_action_lookup_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_ruleID = '0;
   logic [N-1:0]   req_ready, rsp_valid, rsp_action;
   logic           hold = 1'b0;
   logic           ruleID_valid;
   logic [W-1:0]   ruleID;
   logic           action_valid, action;
   logic           err_orphan, err_missing;
   logic [31:0]    lookup_cnt;

   logic           suppress = 1'b0;
   logic           inject = 1'b0;
   logic           inj_act = 1'b0;
   logic [L-1:0]   tv = '0;
   logic [W-1:0]   tr [L];
   int             cyc = 0;
   int             ncmp = 0;
   int             nfail = 0;
   int             d;

   typedef struct { logic [W-1:0] id; int cyc; } iss_t;
   typedef struct { int idx; logic act; int cyc; } rsp_t;
   iss_t iss_q[$];
   rsp_t rsp_q[$];

   action_lookup_arbiter #(.N_REQ(N), .w_ruleID(W), .LAT(L)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ruleID(req_ruleID),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_action(rsp_action), .hold(hold),
      .ruleID_valid(ruleID_valid), .ruleID(ruleID), .action_valid(action_valid),
      .action(action), .err_orphan(err_orphan), .err_missing(err_missing),
      .lookup_cnt(lookup_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // action table: entry r holds r[0], result returned L cycles after the strobe
   always @(posedge clk) begin
      tv    <= {tv[L-2:0], ruleID_valid};
      tr[0] <= ruleID;
      for (int k = 1; k < L; k++) tr[k] <= tr[k-1];
   end
   assign action_valid = (tv[L-1] & ~suppress) | inject;
   assign action       = inject ? inj_act : tr[L-1][0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] id);
      req_valid[i]          = 1'b1;
      req_ruleID[i*W +: W]  = id;
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = '0; hold = 1'b0; inject = 1'b0; suppress = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 4'hF);
      chk("rst_ruleID_valid", ruleID_valid, 0);
      chk("rst_ruleID", ruleID, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_action", rsp_action, 0);
      chk("rst_errs", {err_orphan, err_missing}, 0);
      chk("rst_cnt", lookup_cnt, 0);
      reset = 1'b0;
      repeat (L + 1) @(negedge clk);
   endtask

   always @(negedge clk) begin
      iss_t ei;
      rsp_t er;
      int   idx;
      if (ruleID_valid) begin
         if (iss_q.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL unexpected_issue: ruleID %0h at cycle %0d, none expected", ruleID, cyc);
         end else begin
            ei = iss_q.pop_front();
            chk("issue_ruleID", ruleID, ei.id);
            chk("issue_cycle", cyc, ei.cyc);
         end
      end
      if (rsp_valid != '0) begin
         idx = 0;
         for (int k = N - 1; k >= 0; k--) if (rsp_valid[k]) idx = k;
         if (rsp_q.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL unexpected_rsp: rsp_valid %b at cycle %0d, none expected", rsp_valid, cyc);
         end else begin
            er = rsp_q.pop_front();
            chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
            chk("rsp_idx", idx, er.idx);
            chk("rsp_action", rsp_action[idx], er.act);
            chk("rsp_cycle", cyc, er.cyc);
         end
      end
   end

   initial begin
      @(negedge clk);
      do_reset();

      // single lookup
      d = cyc;
      set_req(2, 16'h0005);
      iss_q.push_back('{16'h0005, d + 2});
      rsp_q.push_back('{2, 1'b1, d + 7});
      @(negedge clk);
      req_valid = '0;
      chk("single_ready_after_accept", req_ready[2], 0);
      @(negedge clk);
      chk("single_ready_after_grant", req_ready[2], 1);
      repeat (8) @(negedge clk);
      chk("single_cnt", lookup_cnt, 1);

      // four-way contention from reset priority
      do_reset();
      d = cyc;
      set_req(0, 16'h0010); set_req(1, 16'h0021); set_req(2, 16'h0032); set_req(3, 16'h0043);
      iss_q.push_back('{16'h0010, d + 2}); iss_q.push_back('{16'h0021, d + 3});
      iss_q.push_back('{16'h0032, d + 4}); iss_q.push_back('{16'h0043, d + 5});
      rsp_q.push_back('{0, 1'b0, d + 7}); rsp_q.push_back('{1, 1'b1, d + 8});
      rsp_q.push_back('{2, 1'b0, d + 9}); rsp_q.push_back('{3, 1'b1, d + 10});
      @(negedge clk);
      req_valid = '0;
      repeat (12) @(negedge clk);
      chk("contention_cnt", lookup_cnt, 4);

      // burst on requester 0 against one request on 1; accept on 0 coincides with grant of 1
      d = cyc;
      set_req(0, 16'h000A); set_req(1, 16'h000B);
      iss_q.push_back('{16'h000A, d + 2}); iss_q.push_back('{16'h000B, d + 3});
      iss_q.push_back('{16'h000A, d + 4});
      rsp_q.push_back('{0, 1'b0, d + 7}); rsp_q.push_back('{1, 1'b1, d + 8});
      rsp_q.push_back('{0, 1'b0, d + 9});
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("burst_ready_regrant", req_ready[0], 1);
      @(negedge clk);
      chk("burst_ready_reaccept", req_ready[0], 0);
      req_valid[0] = 1'b0;
      repeat (10) @(negedge clk);

      // hold window with two requests pending
      hold = 1'b1;
      set_req(1, 16'h0101); set_req(3, 16'h0300);
      @(negedge clk);
      req_valid = '0;
      for (int k = 0; k < 10; k++) begin
         chk("hold_ready1", req_ready[1], 0);
         chk("hold_ready3", req_ready[3], 0);
         chk("hold_no_issue", ruleID_valid, 0);
         @(negedge clk);
      end
      d = cyc;
      hold = 1'b0;
      iss_q.push_back('{16'h0101, d + 1}); iss_q.push_back('{16'h0300, d + 2});
      rsp_q.push_back('{1, 1'b1, d + 6}); rsp_q.push_back('{3, 1'b0, d + 7});
      repeat (10) @(negedge clk);

      // orphan result on an empty pipeline
      chk("orphan_before", err_orphan, 0);
      inject = 1'b1; inj_act = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      chk("orphan_set", err_orphan, 1);
      chk("orphan_no_missing", err_missing, 0);
      repeat (2) @(negedge clk);

      // missing result for an issued lookup
      do_reset();
      suppress = 1'b1;
      d = cyc;
      set_req(0, 16'h0042);
      iss_q.push_back('{16'h0042, d + 2});
      @(negedge clk);
      req_valid = '0;
      repeat (8) @(negedge clk);
      chk("missing_set", err_missing, 1);
      chk("missing_no_orphan", err_orphan, 0);
      suppress = 1'b0;

      // reset two cycles after issue; stale result lands inside the drain window
      do_reset();
      d = cyc;
      set_req(0, 16'h0007);
      iss_q.push_back('{16'h0007, d + 2});
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("midreset_no_orphan", err_orphan, 0);
      chk("midreset_no_missing", err_missing, 0);
      chk("midreset_cnt", lookup_cnt, 0);

      // counter wrap
      repeat (2) @(negedge clk);
      dut.lookup_cnt <= 32'hFFFF_FFFF;
      d = cyc;
      set_req(2, 16'h0005);
      iss_q.push_back('{16'h0005, d + 2});
      rsp_q.push_back('{2, 1'b1, d + 7});
      @(negedge clk);
      req_valid = '0;
      repeat (8) @(negedge clk);
      chk("wrap_cnt", lookup_cnt, 0);
      chk("wrap_no_errs", {err_orphan, err_missing}, 0);

      chk("issues_outstanding", iss_q.size(), 0);
      chk("rsps_outstanding", rsp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/action_lookup_arbiter.md
ACTION_LOOKUP_ARBITER -- requirements
Module: action_lookup_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of lookup requesters.
REQ-002 The block SHALL have parameter w_ruleID, default 16, meaning the ruleID width.
REQ-003 The block SHALL have parameter LAT, default 4, meaning the fixed action-table latency in cycles from ruleID_valid to action_valid.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester lookup request.
REQ-007 req_ruleID  input  N_REQ*w_ruleID  per-requester ruleID; slice i is [i*w_ruleID +: w_ruleID].
REQ-008 req_ready  output  N_REQ  per-requester accept; registered.
REQ-009 rsp_valid  output  N_REQ  one-cycle response pulse to the owning requester.
REQ-010 rsp_action  output  N_REQ  action bit for the owning requester, valid with rsp_valid.
REQ-011 hold  input  1  when 1, blocks new issue to the table (configuration window).
REQ-012 ruleID_valid  output  1  lookup strobe to the action table; registered.
REQ-013 ruleID  output  w_ruleID  lookup key to the action table; registered.
REQ-014 action_valid  input  1  table result strobe.
REQ-015 action  input  1  table result bit.
REQ-016 err_orphan  output  1  sticky: result arrived with no tag.
REQ-017 err_missing  output  1  sticky: tag expired without result.
REQ-018 lookup_cnt  output  32  count of issued lookups; wraps 2^32-1 -> 0.

Function
REQ-019 Each requester SHALL have a one-entry holding register with a pend flag; req_ready[i] SHALL equal ~pend[i], registered.
REQ-020 A request SHALL be accepted when req_valid[i] & req_ready[i] at an edge: ruleID is captured, pend[i] is set, and req_ready[i] drops the next cycle.
REQ-021 Each cycle with hold=0 and any pend set, exactly one requester SHALL be granted, round-robin starting at (last_grant+1) mod N_REQ; the reset value of last_grant is N_REQ-1, so requester 0 has first priority.
REQ-022 On grant: ruleID_valid=1 and ruleID=held key on the next cycle, pend cleared, lookup_cnt incremented, and a tag {valid, requester index} enters a LAT-deep shift pipeline.
REQ-023 With no grant, ruleID_valid SHALL be 0; ruleID SHALL hold its last value.
REQ-024 Issue rate SHALL be up to one lookup per cycle; the table has no backpressure, so the block SHALL never stall the tag pipeline.
REQ-025 A granted requester SHALL be re-acceptable the cycle after grant; back-to-back bursts from one requester SHALL still rotate fairly against other pending requesters.
REQ-026 The tag issued with a ruleID_valid SHALL reach the pipeline head in the cycle its action_valid is expected (LAT cycles later).
REQ-027 When action_valid=1 and the head tag is valid, the next cycle SHALL give rsp_valid[idx]=1 and rsp_action[idx]=action; all other rsp_valid bits SHALL be 0.
REQ-028 Boundary: action_valid=1 with the head tag invalid SHALL set err_orphan and produce no response.
REQ-029 Boundary: the head tag valid with action_valid=0 SHALL set err_missing, drop the tag, and produce no response; the requester is not retried.
REQ-030 Boundary: hold asserting while pend is set SHALL stop grants the next edge; in-flight tags SHALL still complete; acceptance SHALL continue up to the holding-register capacity.
REQ-031 Boundary: simultaneous accept on requester j and grant of requester k≠j in the same cycle SHALL both take effect.
REQ-032 Total latency from accept edge to rsp_valid SHALL be LAT+2 cycles with no contention and hold=0.

Reset
REQ-033 While reset=1: pend, tags, rsp_valid, rsp_action, ruleID_valid, ruleID, err_orphan, err_missing, and lookup_cnt SHALL be 0; req_ready SHALL be all ones; last_grant SHALL be N_REQ-1.
REQ-034 Reset mid-operation SHALL discard held requests and in-flight tags without responses.
REQ-035 For LAT cycles after reset deasserts, action_valid SHALL be ignored (no err_orphan) so that stale table results drain; a drain counter enforces this.

Verification
REQ-036 Single lookup: req_valid[2]=1, ruleID 0x0005, table entry 5 = 1 -> ruleID_valid in cycle 1 with ruleID=0x0005; rsp_valid[2]=1 and rsp_action[2]=1 in cycle 6; lookup_cnt=1.
REQ-037 Contention: all four requesters valid at once -> grants in order 0,1,2,3 on consecutive cycles; responses in the same order in cycles 6-9.
REQ-038 Hold: two requests pending, hold=1 for 10 cycles -> no ruleID_valid while hold=1; req_ready stays 0 for both; issue resumes the cycle after hold drops.
REQ-039 Errors: inject action_valid with an empty pipeline -> err_orphan=1; suppress action_valid for an issued lookup -> err_missing=1 and no rsp_valid.
REQ-040 Reset mid-flight: reset 2 cycles after an issue, then action_valid arrives 2 cycles after deassert -> no response and err_orphan stays 0.
REQ-041 Wrap: preload lookup_cnt to 0xFFFFFFFF and issue one lookup -> lookup_cnt=0.
